// File: rtl/stream_demux.sv
// stream_demux: registered, flow-controlled 1:N stream demultiplexer.
//
// Each input beat is steered by its select to one of N output channels. Every
// channel owns a one-entry output register, so one stalled consumer never
// disturbs traffic to the others. A beat whose select names no channel (only
// possible when N is not a power of two) is consumed and reported through
// drop_pulse one cycle later.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   in_data/in_sel      beat payload and destination channel
//   in_last             end-of-packet flag, carried to the output with the beat
//   in_valid/in_ready   input handshake; in_ready never depends on in_valid
//   out_data[N]         per-channel registered payload
//   out_last[N]         per-channel registered end-of-packet flag
//   out_valid/out_ready per-channel output handshake
//   drop_pulse          one-cycle pulse after an out-of-range beat is consumed
//
// Build option:
//   STREAM_DEMUX_PKT_LOCK_EN  when defined, a packet keeps the channel chosen
//                             by its first beat until its last beat.
//
//   state  | meaning
//   IDLE   | between packets; the effective select follows in_sel
//   LOCKED | inside a packet; the effective select is held at locked_sel
module stream_demux #(
    parameter  int N  = 4,
    parameter  int M  = 8,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [M-1:0]  in_data,
    input  logic [SW-1:0] in_sel,
    input  logic          in_last,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [M-1:0]  out_data [N],
    output logic [N-1:0]  out_last,
    output logic [N-1:0]  out_valid,
    input  logic [N-1:0]  out_ready,
    output logic          drop_pulse
);

    logic [SW-1:0] esel;
    logic [N-1:0]  sel_hit;
    logic          in_range;
    logic          accept;
    logic [N-1:0]  wr_en;

    // Out-of-range selects hit no channel and are always ready, so they can be
    // flushed without waiting on any consumer.
    always_comb begin
        sel_hit  = '0;
        in_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (esel == SW'(i)) begin
                sel_hit[i] = 1'b1;
                in_ready   = !out_valid[i] || out_ready[i];
            end
        end
    end

    assign in_range = |sel_hit;
    assign accept   = in_valid && in_ready;
    assign wr_en    = accept ? sel_hit : '0;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] locked_sel, locked_sel_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            locked_sel <= '0;
        end else begin
            state      <= state_nxt;
            locked_sel <= locked_sel_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        locked_sel_nxt = locked_sel;
        case (state)
            IDLE: begin
                if (accept && !in_last) begin
                    state_nxt      = LOCKED;
                    locked_sel_nxt = in_sel;
                end
            end
            LOCKED: begin
                if (accept && in_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // An out-of-range first beat also locks, so the rest of that packet is
    // dropped beat by beat instead of leaking onto a real channel.
    assign esel = (state == LOCKED) ? locked_sel : in_sel;
`else
    assign esel = in_sel;
`endif

    // A write wins over a drain on the same channel, which keeps out_valid high
    // and sustains one beat per cycle into a continuously ready consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= '0;
            out_last   <= '0;
            drop_pulse <= 1'b0;
            for (int i = 0; i < N; i++) begin
                out_data[i] <= '0;
            end
        end else begin
            drop_pulse <= accept && !in_range;
            for (int i = 0; i < N; i++) begin
                if (wr_en[i]) begin
                    out_valid[i] <= 1'b1;
                    out_data[i]  <= in_data;
                    out_last[i]  <= in_last;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: a 4-channel instance checked every cycle against a
// channel-occupancy scoreboard, plus a 3-channel instance for out-of-range drops.
module tb_stream_demux;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_last, in_valid, in_ready;
    logic [7:0] out_data [4];
    logic [3:0] out_last, out_valid, out_ready;
    logic       drop_pulse;

    logic [7:0] d3_in_data;
    logic [1:0] d3_in_sel;
    logic       d3_in_last, d3_in_valid, d3_in_ready;
    logic [7:0] d3_out_data [3];
    logic [2:0] d3_out_last, d3_out_valid, d3_out_ready;
    logic       d3_drop;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stream_demux #(.N(4), .M(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .drop_pulse(drop_pulse)
    );

    stream_demux #(.N(3), .M(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d3_in_data), .in_sel(d3_in_sel), .in_last(d3_in_last),
        .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .out_data(d3_out_data), .out_last(d3_out_last), .out_valid(d3_out_valid),
        .out_ready(d3_out_ready), .drop_pulse(d3_drop)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pending beats per channel, last payload written per channel,
    // expected drop flag and the packet lock held by the model.
    logic [8:0] q [4][$];
    logic [7:0] mdata [4];
    logic [3:0] mlast;
    logic       drop_exp;
    logic       lk_act;
    logic [1:0] lk_ch;

    always @(negedge clk) begin
        logic [1:0] es;
        logic       rdy, drop_nxt, oor;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                q[i].delete();
                mdata[i] = 8'h00;
            end
            mlast    = '0;
            drop_exp = 1'b0;
            lk_act   = 1'b0;
            lk_ch    = '0;
        end else begin
            es = in_sel;
`ifdef STREAM_DEMUX_PKT_LOCK_EN
            if (lk_act) es = lk_ch;
`endif
            oor = (int'(es) >= N);
            rdy = oor || (q[es].size() == 0) || out_ready[es];
            for (int i = 0; i < N; i++) begin
                chk($sformatf("out_valid[%0d]", i), out_valid[i], q[i].size() != 0);
                chk($sformatf("out_data[%0d]", i), out_data[i], mdata[i]);
                chk($sformatf("out_last[%0d]", i), out_last[i], mlast[i]);
            end
            chk("in_ready", in_ready, rdy);
            chk("drop_pulse", drop_pulse, drop_exp);

            for (int i = 0; i < N; i++)
                if (q[i].size() != 0 && out_ready[i]) void'(q[i].pop_front());
            drop_nxt = 1'b0;
            if (in_valid && rdy) begin
                if (oor) drop_nxt = 1'b1;
                else begin
                    q[es].push_back({in_last, in_data});
                    mdata[es] = in_data;
                    mlast[es] = in_last;
                end
`ifdef STREAM_DEMUX_PKT_LOCK_EN
                if (!lk_act && !in_last) begin
                    lk_act = 1'b1;
                    lk_ch  = in_sel;
                end else if (lk_act && in_last) begin
                    lk_act = 1'b0;
                end
`endif
            end
            drop_exp = drop_nxt;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic l);
        int k = 0;
        in_data  = d;
        in_sel   = s;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        in_valid = 0; in_data = 0; in_sel = 0; in_last = 0; out_ready = 4'hF;
        d3_in_valid = 0; d3_in_data = 0; d3_in_sel = 0; d3_in_last = 0; d3_out_ready = 3'b111;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_out_data0", out_data[0], 8'h00);
        chk("rst_drop", drop_pulse, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick;

        // Single beats to three channels, all consumers ready.
        send(8'hA1, 2'd0, 1'b1);
        @(negedge clk);
        chk("t1_valid_a1", out_valid, 4'b0001);
        chk("t1_data_a1", out_data[0], 8'hA1);
        tick;
        @(negedge clk);
        chk("t1_valid_one_cycle", out_valid, 4'b0000);
        tick;
        send(8'hB2, 2'd1, 1'b1);
        @(negedge clk);
        chk("t1_valid_b2", out_valid, 4'b0010);
        chk("t1_data_b2", out_data[1], 8'hB2);
        tick;
        send(8'hC3, 2'd3, 1'b1);
        @(negedge clk);
        chk("t1_valid_c3", out_valid, 4'b1000);
        chk("t1_data_c3", out_data[3], 8'hC3);
        tick;

        // Stalled channel 2 while channel 0 keeps flowing.
        out_ready = 4'b1011;
        send(8'h11, 2'd2, 1'b1);
        @(negedge clk);
        chk("t2_data_11", out_data[2], 8'h11);
        tick;
        in_data = 8'h22; in_sel = 2'd2; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("t2_blocked", in_ready, 1'b0);
        tick;
        @(negedge clk);
        chk("t2_stable_11", out_data[2], 8'h11);
        tick;
        in_valid = 1'b0;
        send(8'h33, 2'd0, 1'b1);
        @(negedge clk);
        chk("t2_data_33", out_data[0], 8'h33);
        chk("t2_ch2_held", out_valid[2], 1'b1);
        tick;
        out_ready = 4'b1111;
        in_data = 8'h22; in_sel = 2'd2; in_valid = 1'b1;
        @(negedge clk);
        chk("t2_ready_on_drain", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("t2_replace_valid", out_valid[2], 1'b1);
        chk("t2_replace_data", out_data[2], 8'h22);
        tick;

        // Back-to-back stream into channel 1.
        start = cyc;
        for (int k = 0; k < 6; k++) send(8'h40 + 8'(k), 2'd1, 1'b1);
        chk("t3_cycles", cyc - start, 6);
        @(negedge clk);
        chk("t3_last_data", out_data[1], 8'h45);
        tick;

        // Asynchronous reset with two channels occupied.
        out_ready = 4'b1100;
        send(8'h61, 2'd0, 1'b1);
        send(8'h62, 2'd1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", out_valid, 4'b0000);
        chk("t5_rst_data0", out_data[0], 8'h00);
        chk("t5_rst_data1", out_data[1], 8'h00);
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 4'b1111;
        send(8'h77, 2'd3, 1'b1);
        @(negedge clk);
        chk("t5_after_valid", out_valid, 4'b1000);
        chk("t5_after_data", out_data[3], 8'h77);
        tick;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
        // Packet lock: the whole packet follows the first beat's select.
        send(8'hD1, 2'd2, 1'b0);
        send(8'hD2, 2'd0, 1'b0);
        send(8'hD3, 2'd1, 1'b1);
        @(negedge clk);
        chk("t6_lock_valid", out_valid, 4'b0100);
        chk("t6_lock_data", out_data[2], 8'hD3);
        tick;
        send(8'hE4, 2'd0, 1'b1);
        @(negedge clk);
        chk("t6_unlock_valid", out_valid, 4'b0001);
        chk("t6_unlock_data", out_data[0], 8'hE4);
        tick;
`endif

        // N=3: select 3 is out of range and is dropped.
        d3_in_data = 8'h5A; d3_in_sel = 2'd3; d3_in_last = 1'b1; d3_in_valid = 1'b1;
        @(negedge clk);
        chk("t4_ready_oor", d3_in_ready, 1'b1);
        @(posedge clk);
        #1 d3_in_valid = 1'b0;
        @(negedge clk);
        chk("t4_drop_high", d3_drop, 1'b1);
        chk("t4_no_valid", d3_out_valid, 3'b000);
        tick;
        @(negedge clk);
        chk("t4_drop_low", d3_drop, 1'b0);
        chk("t4_still_no_valid", d3_out_valid, 3'b000);
        tick;
        d3_in_data = 8'h5B; d3_in_sel = 2'd2; d3_in_valid = 1'b1;
        @(negedge clk);
        chk("t4_ready_ch2", d3_in_ready, 1'b1);
        @(posedge clk);
        #1 d3_in_valid = 1'b0;
        @(negedge clk);
        chk("t4_ch2_valid", d3_out_valid, 3'b100);
        chk("t4_ch2_data", d3_out_data[2], 8'h5B);
        chk("t4_ch2_nodrop", d3_drop, 1'b0);
        tick;

        repeat (2) tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
